elem_reader: RTL and testbench
==============================

# elem_reader

Parametrised Avalon-MM read master that fetches one element of NWORDS bus words from `baseaddr + index*ESIZE` and delivers the assembled element on a valid/ready stream. It is the next generation of the triangle reader: bus width, element size and buffer depth are configurable, and it has credit-based backpressure. It keeps up to DEPTH elements in flight or buffered, and returns them in request order. It sits between the raytracer core's scene-fetch logic and the SDRAM Avalon port.

## Interface
- DATAW, 16: Avalon data width in bits; multiple of 8.
- NWORDS, 2: bus words per element. Element width EW = DATAW*NWORDS.
- DEPTH, 4: maximum elements reserved, counting in flight plus buffered. Power of 2, ≥2.
- Derived: WB = DATAW/8 bytes per word; ESIZE = NWORDS*WB bytes per element.

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- baseaddr  in  32  byte base address; sampled on command accept.
- index  in  32  element index; sampled on command accept.
- read  in  1  command valid.
- ready  out  1  command can be accepted.
- data  out  EW  element at the output buffer head.
- ovalid  out  1  `data` is valid.
- iready  in  1  consumer accepts `data`.
- avm_m0_read  out  1  Avalon read request.
- avm_m0_write  out  1  constant 0.
- avm_m0_writedata  out  DATAW  constant 0.
- avm_m0_address  out  32  byte address.
- avm_m0_byteenable  out  WB  constant all ones.
- avm_m0_readdata  in  DATAW  read response data.
- avm_m0_readdatavalid  in  1  response beat valid.
- avm_m0_waitrequest  in  1  slave stall.

## Operation
- Command accept: `read && ready`. `ready = (state==IDLE) && (credits != 0)`.
- Credits:
  - counter of width $clog2(DEPTH+1); resets to DEPTH.
  - minus 1 on accept, plus 1 on output handshake (`ovalid && iready`).
  - both in one cycle: net 0.
  - Reads are only issued with a credit held, so responses never overflow the buffer.
- Address: `addr0 = baseaddr + index*ESIZE`, computed modulo 2^32 with silent wrap. Word k uses `addr0 + k*WB`.
- Issue FSM:
  - IDLE: on accept, latch addr0, set word counter wc=0, go to ISSUE.
  - ISSUE: `avm_m0_read=1`, `avm_m0_address=addr0+wc*WB`; all outputs registered.
  - In ISSUE, when `waitrequest=0` the word is accepted and wc increments. If wc==NWORDS-1, go to IDLE and drop `avm_m0_read` next cycle.
  - In ISSUE, while `waitrequest=1`, address and read hold stable.
- Outstanding-beat counter:
  - +1 per accepted read word, -1 per readdatavalid beat.
  - A readdatavalid beat arriving while the counter is 0 is discarded. This covers stale responses after reset.
- Assembler:
  - Beats shift in MSB-first: the first beat of an element ends in bits [EW-1 -: DATAW], the last beat in [DATAW-1:0].
  - A beat counter triggers a push into the output FIFO after NWORDS beats.
- Output FIFO:
  - DEPTH entries, first-word fall-through.
  - `ovalid = !empty`; `data` = head entry.
  - Pop on `ovalid && iready`.
  - Push and pop in the same cycle are both performed.
  - Full is never reached with a push pending, because of credits.
- Elements are returned in command order; the Avalon slave returns beats in order.

## Timing
- Reset values:
  - ready=1, ovalid=0, data=0.
  - avm_m0_read=0, avm_m0_address=0.
  - credits=DEPTH; all counters 0; state IDLE.
- Reset asserted mid-element: everything aborts immediately. Partial elements and buffered elements are lost.
- Command accepted at edge T:
  - `avm_m0_read` is high from cycle T+1.
  - With no waitrequest, the last word issues in cycle T+NWORDS.
  - ready returns high in cycle T+NWORDS+1, if a credit remains.
- Command rate: one element per NWORDS+1 cycles maximum.
- Response latency: last beat seen at edge R gives `ovalid=1` in cycle R+1. Data is held stable until it is popped.
- ovalid stays high with data stable while `iready=0`.
- With all DEPTH credits consumed, ready stays 0 until the cycle after the first pop.

## Test plan
All scenarios use DATAW=16, NWORDS=2, DEPTH=4 unless stated.
- Single read: baseaddr=0x100, index=3.
  - Reads issue at 0x10C then 0x10E.
  - Beats 0x000A, 0x000B, then iready=1.
  - Required: data=0x000A000B, ovalid high for exactly 1 cycle.
- Waitrequest stall: waitrequest=1 for 3 cycles on word 0.
  - Required: address 0x10C held and read held high.
  - Word 1 issues the cycle after release.
- Credit exhaustion: issue indices 0..5 with iready=0, memory returning 0x0001..0x0008.
  - Required: only 4 commands accepted and ready=0 afterwards.
  - After one pop, ready=1 the next cycle.
  - Outputs in order: 0x00010002, 0x00030004, 0x00050006, 0x00070008.
- Simultaneous push and pop with credit return and accept in the same cycle.
  - Required: credits unchanged, no element lost or duplicated.
- Address wrap: baseaddr=0xFFFFFFFC, index=1.
  - Required: reads at 0x00000000 and 0x00000002.
- Reset mid-operation: reset asserted after word 0 issues, then a stale readdatavalid beat 0xDEAD arrives after reset releases.
  - Required: all outputs at reset values, the beat is discarded, ovalid stays 0.
  - Next read at index 0 returns the correct element.

Source files
------------

// File: rtl/elem_reader.sv
// Avalon-MM read master: fetches NWORDS-word elements at baseaddr + index*ESIZE and
// returns them in request order on a valid/ready stream, with credit-based backpressure.
module elem_reader #(
  parameter int DATAW  = 16,
  parameter int NWORDS = 2,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             baseaddr,
  input  logic [31:0]             index,
  input  logic                    read,
  output logic                    ready,
  output logic [DATAW*NWORDS-1:0] data,
  output logic                    ovalid,
  input  logic                    iready,
  output logic                    avm_m0_read,
  output logic                    avm_m0_write,
  output logic [DATAW-1:0]        avm_m0_writedata,
  output logic [31:0]             avm_m0_address,
  output logic [DATAW/8-1:0]      avm_m0_byteenable,
  input  logic [DATAW-1:0]        avm_m0_readdata,
  input  logic                    avm_m0_readdatavalid,
  input  logic                    avm_m0_waitrequest
);
  localparam int EW    = DATAW * NWORDS;
  localparam int WB    = DATAW / 8;
  localparam int ESIZE = NWORDS * WB;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(DEPTH);
  localparam int WCW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int OW    = $clog2(DEPTH * NWORDS + 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t          state;
  logic [WCW-1:0]  wc;
  logic [WCW-1:0]  bc;
  logic [CW-1:0]   credits;
  logic [CW-1:0]   count;
  logic [OW-1:0]   outstanding;
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [EW-1:0]   partial;
  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   elem;
  logic            accept;
  logic            pop;
  logic            word_acc;
  logic            beat;
  logic            push;

  // Oldest beat ends up in the top word once NWORDS beats have been shifted in.
  function automatic logic [EW-1:0] shift_beat(input logic [EW-1:0] acc,
                                               input logic [DATAW-1:0] b);
    return EW'({acc, b});
  endfunction

  assign ready             = (state == IDLE) && (credits != '0);
  assign accept            = read && ready;
  assign ovalid            = (count != '0);
  assign pop               = ovalid && iready;
  assign word_acc          = avm_m0_read && !avm_m0_waitrequest;
  assign beat              = avm_m0_readdatavalid && (outstanding != '0);
  assign elem              = shift_beat(partial, avm_m0_readdata);
  assign push              = beat && (bc == WCW'(NWORDS - 1));
  assign data              = ovalid ? mem[rptr] : '0;
  assign avm_m0_write      = 1'b0;
  assign avm_m0_writedata  = '0;
  assign avm_m0_byteenable = '1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      wc             <= '0;
      avm_m0_read    <= 1'b0;
      avm_m0_address <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            avm_m0_address <= baseaddr + index * 32'(ESIZE);
            avm_m0_read    <= 1'b1;
            wc             <= '0;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          if (!avm_m0_waitrequest) begin
            if (wc == WCW'(NWORDS - 1)) begin
              avm_m0_read <= 1'b0;
              state       <= IDLE;
            end else begin
              wc             <= wc + WCW'(1);
              avm_m0_address <= avm_m0_address + 32'(WB);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A credit is held from command accept until the element leaves the output buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits     <= CW'(DEPTH);
      outstanding <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: ;
      endcase
      case ({word_acc, beat})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bc    <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (beat) bc <= push ? '0 : bc + WCW'(1);
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (beat) partial <= elem;
    if (push) mem[wptr] <= elem;
  end

endmodule

// File: tb/tb_elem_reader.sv
// Bench for elem_reader: directed vector table, multi-cycle corner sequences and a
// randomized phase, all checked against a transaction-level model with an Avalon slave.
module tb_elem_reader;
  localparam int DATAW  = 16;
  localparam int NWORDS = 2;
  localparam int DEPTH  = 4;
  localparam int WB     = DATAW / 8;
  localparam int EW     = DATAW * NWORDS;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       baseaddr;
  logic [31:0]       index;
  logic              read;
  logic              ready;
  logic [EW-1:0]     data;
  logic              ovalid;
  logic              iready;
  logic              avm_m0_read;
  logic              avm_m0_write;
  logic [DATAW-1:0]  avm_m0_writedata;
  logic [31:0]       avm_m0_address;
  logic [WB-1:0]     avm_m0_byteenable;
  logic [DATAW-1:0]  avm_m0_readdata;
  logic              avm_m0_readdatavalid;
  logic              avm_m0_waitrequest;

  elem_reader #(.DATAW(DATAW), .NWORDS(NWORDS), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .baseaddr(baseaddr), .index(index), .read(read),
    .ready(ready), .data(data), .ovalid(ovalid), .iready(iready),
    .avm_m0_read(avm_m0_read), .avm_m0_write(avm_m0_write),
    .avm_m0_writedata(avm_m0_writedata), .avm_m0_address(avm_m0_address),
    .avm_m0_byteenable(avm_m0_byteenable), .avm_m0_readdata(avm_m0_readdata),
    .avm_m0_readdatavalid(avm_m0_readdatavalid), .avm_m0_waitrequest(avm_m0_waitrequest)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [EW-1:0]    exp_q[$];
  logic [EW-1:0]    got_q[$];
  logic [31:0]      iss_q[$];
  logic [DATAW-1:0] pend_q[$];
  int               due_q[$];
  logic [DATAW-1:0] mem_ovr [logic [31:0]];
  int n_acc, n_pop, n_iss, n_beats;
  bit hold_resp, rand_wait;
  int lat_max;

  typedef struct {
    logic [31:0]   base;
    logic [31:0]   idx;
    logic [31:0]   a0;
    logic [EW-1:0] d;
  } vec_t;
  vec_t vt[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [DATAW-1:0] mem_word(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return DATAW'(a / 32'(WB) + 32'd1);
  endfunction

  function automatic logic [EW-1:0] exp_elem(input logic [31:0] a0);
    logic [EW-1:0] e;
    e = '0;
    for (int k = 0; k < NWORDS; k++)
      e = e | (EW'(mem_word(a0 + 32'(k * WB))) << (DATAW * (NWORDS - 1 - k)));
    return e;
  endfunction

  // One clock: log the handshakes that the coming edge will perform, then model and check.
  task automatic step();
    bit acc, pp, wacc, bt;
    logic [EW-1:0] head;
    acc  = read && ready;
    pp   = ovalid && iready;
    wacc = avm_m0_read && !avm_m0_waitrequest;
    bt   = avm_m0_readdatavalid && (n_iss > n_beats);
    if (wacc) begin
      iss_q.push_back(avm_m0_address);
      pend_q.push_back(mem_word(avm_m0_address));
      due_q.push_back(cyc + 1 + $urandom_range(0, lat_max));
      n_iss++;
    end
    if (bt) n_beats++;
    if (pp) begin
      if (exp_q.size() == 0) fail_now("pop_without_command");
      else begin
        head = exp_q.pop_front();
        got_q.push_back(data);
        chk("pop_data", data, head);
      end
      n_pop++;
    end
    if (acc) begin
      exp_q.push_back(exp_elem(baseaddr + index * 32'(NWORDS * WB)));
      n_acc++;
    end
    @(posedge clk);
    #1;
    cyc++;
    avm_m0_readdatavalid = 1'b0;
    avm_m0_readdata      = DATAW'($urandom);
    if (!hold_resp && pend_q.size() > 0 && due_q[0] <= cyc) begin
      avm_m0_readdatavalid = 1'b1;
      avm_m0_readdata      = pend_q.pop_front();
      due_q.delete(0);
    end
    if (rand_wait) avm_m0_waitrequest = ($urandom_range(0, 3) == 0);
    chk("ready", ready, (n_acc - n_pop < DEPTH) && (n_iss == n_acc * NWORDS));
    chk("avm_read", avm_m0_read, n_iss < n_acc * NWORDS);
    chk("ovalid", ovalid, (n_beats / NWORDS) > n_pop);
    if (ovalid && exp_q.size() > 0) chk("head_data", data, exp_q[0]);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    read = 1'b0;
    iready = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_ready", ready, 1'b1);
    chk("rst_ovalid", ovalid, 1'b0);
    chk("rst_data", data, '0);
    chk("rst_avm_read", avm_m0_read, 1'b0);
    chk("rst_avm_addr", avm_m0_address, 32'h0);
    chk("rst_avm_write", avm_m0_write, 1'b0);
    chk("rst_byteenable", avm_m0_byteenable, {WB{1'b1}});
    exp_q.delete(); pend_q.delete(); due_q.delete();
    n_acc = 0; n_pop = 0; n_iss = 0; n_beats = 0;
    avm_m0_readdatavalid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    cyc += 2;
    reset = 1'b0;
  endtask

  task automatic fill(input logic [31:0] base, input int ncmd, input int ncyc, output int nacc);
    int nxt, a0;
    nxt = 0;
    a0 = n_acc;
    baseaddr = base;
    for (int c = 0; c < ncyc; c++) begin
      index = nxt;
      read  = (nxt < ncmd);
      step();
      nxt = n_acc - a0;
    end
    read = 1'b0;
    nacc = n_acc - a0;
  endtask

  initial begin
    int nacc, ovc;
    logic [EW-1:0] cred_exp [4];
    read = 0; iready = 0; baseaddr = 0; index = 0;
    avm_m0_readdata = 0; avm_m0_readdatavalid = 0; avm_m0_waitrequest = 0;
    hold_resp = 0; rand_wait = 0; lat_max = 0;
    mem_ovr[32'h10C] = 16'h000A;
    mem_ovr[32'h10E] = 16'h000B;
    vt[0] = '{32'h0000_0100, 32'd3,          32'h0000_010C, 32'h000A_000B};
    vt[1] = '{32'hFFFF_FFFC, 32'd1,          32'h0000_0000, 32'h0001_0002};
    vt[2] = '{32'h0000_1000, 32'h10,         32'h0000_1040, 32'h0821_0822};
    vt[3] = '{32'h0000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFC, 32'hFFFF_0000};
    cred_exp = '{32'h0001_0002, 32'h0003_0004, 32'h0005_0006, 32'h0007_0008};

    do_reset();

    // Directed single reads, including address wrap.
    for (int i = 0; i < 4; i++) begin
      iss_q.delete(); got_q.delete();
      baseaddr = vt[i].base; index = vt[i].idx; iready = 1'b1; read = 1'b1;
      step();
      read = 1'b0;
      ovc = 0;
      for (int c = 0; c < 12; c++) begin
        step();
        if (ovalid) ovc++;
      end
      if (iss_q.size() < NWORDS) fail_now("tbl_issue_count");
      else begin
        chk("tbl_addr0", iss_q[0], vt[i].a0);
        chk("tbl_addr1", iss_q[1], vt[i].a0 + 32'(WB));
      end
      if (got_q.size() != 1) fail_now("tbl_output_count");
      else chk("tbl_data", got_q[0], vt[i].d);
      chk("tbl_ovalid_cycles", ovc, 1);
    end

    // Waitrequest held for three cycles on word 0.
    avm_m0_waitrequest = 1'b1;
    baseaddr = 32'h100; index = 3; read = 1'b1;
    step();
    read = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk("stall_read", avm_m0_read, 1'b1);
      chk("stall_addr", avm_m0_address, 32'h10C);
      step();
    end
    avm_m0_waitrequest = 1'b0;
    chk("stall_addr_release", avm_m0_address, 32'h10C);
    step();
    chk("stall_word1_read", avm_m0_read, 1'b1);
    chk("stall_word1_addr", avm_m0_address, 32'h10E);
    step();
    chk("stall_read_drop", avm_m0_read, 1'b0);
    run(8);

    // Credit exhaustion with the consumer stalled.
    iready = 1'b0; got_q.delete();
    fill(32'h0, 6, 40, nacc);
    chk("cred_accepted", nacc, 4);
    chk("cred_ready_low", ready, 1'b0);
    iready = 1'b1;
    step();
    iready = 1'b0;
    chk("cred_ready_after_pop", ready, 1'b1);
    iready = 1'b1;
    run(8);
    if (got_q.size() != 4) fail_now("cred_output_count");
    else for (int i = 0; i < 4; i++) chk("cred_order", got_q[i], cred_exp[i]);

    // Push, pop, credit return and accept all on one edge.
    iready = 1'b0; got_q.delete(); baseaddr = 32'h2000;
    index = 0; read = 1'b1; step(); read = 1'b0; run(4);
    index = 1; read = 1'b1; step(); read = 1'b0; run(6);
    hold_resp = 1'b1;
    index = 2; read = 1'b1; step(); read = 1'b0; run(3);
    chk("sim_setup_ready", ready, 1'b1);
    hold_resp = 1'b0;
    run(2);
    index = 3; read = 1'b1; iready = 1'b1;
    chk("sim_setup_beat", avm_m0_readdatavalid, 1'b1);
    chk("sim_setup_ovalid", ovalid, 1'b1);
    chk("sim_setup_ready2", ready, 1'b1);
    step();
    read = 1'b0; iready = 1'b0;
    run(8);
    iready = 1'b1;
    run(8);
    if (got_q.size() != 4) fail_now("sim_output_count");
    else for (int i = 0; i < 4; i++)
      chk("sim_order", got_q[i], exp_elem(32'h2000 + 32'(i * NWORDS * WB)));
    iready = 1'b0;
    fill(32'h3000, 6, 30, nacc);
    chk("sim_credits_restored", nacc, DEPTH);
    iready = 1'b1;
    run(10);

    // Reset after word 0 issues, then a stale beat.
    hold_resp = 1'b1;
    baseaddr = 32'h0; index = 5; read = 1'b1;
    step();
    read = 1'b0;
    step();
    do_reset();
    hold_resp = 1'b0;
    avm_m0_readdatavalid = 1'b1;
    avm_m0_readdata = 16'hDEAD;
    step();
    run(4);
    chk("stale_ovalid", ovalid, 1'b0);
    got_q.delete();
    baseaddr = 32'h0; index = 0; iready = 1'b1; read = 1'b1;
    step();
    read = 1'b0;
    run(8);
    if (got_q.size() != 1) fail_now("post_reset_output_count");
    else chk("post_reset_data", got_q[0], 32'h0001_0002);

    // Randomized traffic with waitrequest and variable response latency.
    rand_wait = 1'b1; lat_max = 3;
    for (int c = 0; c < 1500; c++) begin
      read     = ($urandom_range(0, 1) == 1);
      baseaddr = $urandom;
      index    = $urandom;
      iready   = ($urandom_range(0, 3) != 0);
      step();
    end
    rand_wait = 1'b0; avm_m0_waitrequest = 1'b0;
    read = 1'b0; iready = 1'b1;
    run(40);
    chk("rand_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
